// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues single-outstanding word reads to
// instruction memory over req/ack, buffers returned words in a small FIFO and
// presents the head instruction with its decoded fields to the Controller.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  stall,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [3:0]            cond,
    output logic [1:0]            op,
    output logic [5:0]            funct,
    output logic [3:0]            rd,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus8
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        FULL    = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] fetch_pc_inc;
    logic [ADDR_WIDTH-1:0] redirect_target;

    // Instruction buffer: data storage plus pointer/count control.
    logic [31:0]           buf_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_after;

    logic                  push;
    logic                  pop;
    logic [31:0]           head_instr;
    logic [ADDR_WIDTH-1:0] head_pc;

    // Circular pointer advance that also works for non power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Branch targets are forced word aligned; low address bits are dropped.
    assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
    assign fetch_pc_inc    = fetch_pc + ADDR_WIDTH'(4);

    // Redirect overrides both sides of the buffer: returned data is dropped
    // and the consumer does not pop a head that is about to be flushed.
    assign instr_valid = (count != '0);
    assign pop         = instr_valid & ~stall & ~redirect;
    assign push        = (state == FETCH) & imem_ack & ~redirect;

    // Occupancy after this edge ignoring flush; decides FETCH vs FULL.
    always_comb begin
        count_after = count;
        if (push && !pop) begin
            count_after = count + 1'b1;
        end else if (pop && !push) begin
            count_after = count - 1'b1;
        end
    end

    // Fetch FSM with registered request/address outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (redirect) begin
                        fetch_pc  <= redirect_target;
                        imem_addr <= redirect_target;
                    end else begin
                        imem_addr <= fetch_pc;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        fetch_pc <= redirect_target;
                        if (imem_ack) begin
                            // Returned word belongs to the old path; reissue at target.
                            state     <= FETCH;
                            imem_req  <= 1'b1;
                            imem_addr <= redirect_target;
                        end else begin
                            // Request in flight must complete at its original address.
                            state <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        fetch_pc <= fetch_pc_inc;
                        if (count_after < DEPTH_CNT) begin
                            state     <= FETCH;
                            imem_req  <= 1'b1;
                            imem_addr <= fetch_pc_inc;
                        end else begin
                            state    <= FULL;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        fetch_pc <= redirect_target;
                    end
                    if (imem_ack) begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= redirect ? redirect_target : fetch_pc;
                    end
                end
                FULL: begin
                    if (redirect) begin
                        fetch_pc  <= redirect_target;
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= redirect_target;
                    end else if (pop) begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Buffer control: pointers and occupancy, cleared by reset or redirect.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count_after;
        end
    end

    // Buffer storage: word and its fetch address, written on accepted ack.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= fetch_pc;
        end
    end

    assign head_instr = buf_instr[rd_ptr];
    assign head_pc    = buf_pc[rd_ptr];

    // Head presentation is forced to zero whenever the buffer is empty.
    assign instr    = instr_valid ? head_instr : '0;
    assign cond     = instr[31:28];
    assign op       = instr[27:26];
    assign funct    = instr[25:20];
    assign rd       = instr[15:12];
    assign pc       = instr_valid ? head_pc : '0;
    assign pc_plus8 = instr_valid ? head_pc + ADDR_WIDTH'(8) : '0;

endmodule
